// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RISC-V instruction fetch stage: PC register, next-PC mux and IF/ID register
// Optional performance counters fetch_cnt/bubble_cnt enabled by `define FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcsrcE,
  input  logic [31:0] pctargetE,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt,
`endif
  output logic        validD
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pcd;
  logic [31:0] r_pcplus4d;
  logic        r_valid;
  logic [31:0] w_pcplus4;

  assign w_pcplus4 = r_pc + 32'd4;
  // Address comes straight from the PC register so memory never sees the redirect mux.
  assign imem_addr = r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (pcsrcE) begin
      r_pc <= pctargetE;
    end else if (!stallF && imem_valid) begin
      r_pc <= w_pcplus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flushD || (!stallD && !imem_valid)) begin
      r_instr    <= NOP_INSTR;
      r_pcd      <= 32'd0;
      r_pcplus4d <= 32'd0;
      r_valid    <= 1'b0;
    end else if (!stallD) begin
      r_instr    <= imem_rdata;
      r_pcd      <= r_pc;
      r_pcplus4d <= w_pcplus4;
      r_valid    <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else if (flushD || (!stallD && !imem_valid)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end else if (!stallD) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

  assign instrD   = r_instr;
  assign pcD      = r_pcd;
  assign pcplus4D = r_pcplus4d;
  assign validD   = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stallF, stallD, flushD, pcsrcE, imem_valid;
  logic [31:0] pctargetE, imem_addr, imem_rdata, instrD, pcD, pcplus4D;
  logic        validD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage #(.RESET_PC(32'h100), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .pcsrcE(pcsrcE), .pctargetE(pctargetE), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instrD(instrD),
    .pcD(pcD), .pcplus4D(pcplus4D),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt),
`endif
    .validD(validD)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; stallF = 0; stallD = 0; flushD = 0; pcsrcE = 0;
    pctargetE = 32'h0; imem_valid = 1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    idle();
    pcsrcE = 1; pctargetE = tgt; flushD = 1;
    step();
    idle();
  endtask

  initial begin
    idle();
    rst = 1; imem_valid = 0;
    step(); step();
    check("rst_addr", imem_addr, 32'h100);
    check("rst_instr", instrD, NOP);
    check("rst_valid", {31'd0, validD}, 32'd0);
    check("rst_pcD", pcD, 32'd0);
    check("rst_pcplus4D", pcplus4D, 32'd0);

    idle();
    step();
    check("f1_pc", imem_addr, 32'h104);
    check("f1_instr", instrD, mem_word(32'h100));
    check("f1_pcD", pcD, 32'h100);
    check("f1_pcplus4D", pcplus4D, 32'h104);
    check("f1_valid", {31'd0, validD}, 32'd1);
    step(); step();
    check("f3_pcD", pcD, 32'h108);
    check("f3_pc", imem_addr, 32'h10C);

    redirect(32'h10);
    check("wait_pc0", imem_addr, 32'h10);
    imem_valid = 0;
    step();
    check("wait1_pc", imem_addr, 32'h10);
    check("wait1_valid", {31'd0, validD}, 32'd0);
    check("wait1_instr", instrD, NOP);
    step();
    check("wait2_pc", imem_addr, 32'h10);
    check("wait2_valid", {31'd0, validD}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("cnt_fetch", fetch_cnt, 32'd3);
    check("cnt_bubble", bubble_cnt, 32'd3);
`endif
    imem_valid = 1;
    step();
    check("resume_pc", imem_addr, 32'h14);
    check("resume_instr", instrD, mem_word(32'h10));
    check("resume_valid", {31'd0, validD}, 32'd1);

    redirect(32'h20);
    step();
    check("pre_redir_pc", imem_addr, 32'h24);
    redirect(32'h20);
    pcsrcE = 1; pctargetE = 32'h80; flushD = 1;
    step();
    idle();
    check("redir_pc", imem_addr, 32'h80);
    check("redir_instr", instrD, NOP);
    check("redir_valid", {31'd0, validD}, 32'd0);

    redirect(32'h40);
    stallF = 1; stallD = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", imem_addr, 32'h40);
      check("stall_instr", instrD, NOP);
      check("stall_pcD", pcD, 32'h0);
    end
    idle();
    step();
    check("release_pc", imem_addr, 32'h44);
    check("release_pcD", pcD, 32'h40);

    pcsrcE = 1; pctargetE = 32'h1234; stallF = 1; imem_valid = 0;
    step();
    idle();
    check("sim_redir_pc", imem_addr, 32'h1234);
    check("sim_redir_valid", {31'd0, validD}, 32'd0);
    rst = 1; pcsrcE = 1; pctargetE = 32'h80; stallF = 1; stallD = 1;
    step();
    idle();
    check("rst_over_redir_pc", imem_addr, 32'h100);
    check("rst_over_redir_valid", {31'd0, validD}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("cnt_rst_fetch", fetch_cnt, 32'd0);
    check("cnt_rst_bubble", bubble_cnt, 32'd0);
`endif

    redirect(32'hFFFF_FFFC);
    step();
    check("wrap_pc", imem_addr, 32'h0);
    check("wrap_pcplus4D", pcplus4D, 32'h0);
    check("wrap_pcD", pcD, 32'hFFFF_FFFC);
    check("wrap_valid", {31'd0, validD}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
